// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity mode codes and the
// baud divisor helper used by both the receive and transmit cores.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Restartable bit-period counter: counts 0..DIV-1 while enabled and raises a
// one-cycle tick at HALF-1, i.e. the middle of each bit once cleared on a start edge.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV  = 5208,
  parameter int unsigned HALF = DIV / 2
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == CW'(DIV - 1)) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = enable && !clear && (cnt == CW'(HALF - 1));

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver with glitch-rejecting start detect, framing/parity
// status and a valid/ready holding register. Parity support built with UART_RX_PARITY_EN.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BAUD        = 9600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic [1:0]           parity_mode,
  input  logic                 data_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned HALF     = BAUD_DIV / 2;
  localparam int unsigned BW       = $clog2(DATA_BITS);

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic                   start_edge;
  logic                   tick;
  logic                   par_active;
  rx_state_t              state;
  logic [BW-1:0]          bit_cnt;
  logic                   stop_cnt;
  logic [DATA_BITS-1:0]   shift;
  logic                   ferr_acc;
  logic                   commit;
  logic                   commit_ferr;

  // Synchroniser presets high so reset release never looks like a start edge
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) sync <= '1;
    else        sync <= {sync[SYNC_STAGES-2:0], rx};
  end

  assign rx_s       = sync[SYNC_STAGES-1];
  assign start_edge = (state == IDLE) && sync[SYNC_STAGES-1] && !sync[SYNC_STAGES-2];
  assign busy       = (state != IDLE);

  uart_baud_tick #(
    .DIV  (BAUD_DIV),
    .HALF (HALF)
  ) u_baud (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .clear   (start_edge),
    .enable  (busy),
    .tick    (tick)
  );

  // FSM returns to IDLE at the final mid-stop sample; commit follows one cycle later
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      shift       <= '0;
      ferr_acc    <= 1'b0;
      commit      <= 1'b0;
      commit_ferr <= 1'b0;
    end else begin
      commit <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state    <= START;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            ferr_acc <= 1'b0;
          end
        end
        START: begin
          if (tick) state <= rx_s ? IDLE : DATA;
        end
        DATA: begin
          if (tick) begin
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_cnt == BW'(DATA_BITS - 1)) state <= par_active ? PARITY : STOP;
            else                               bit_cnt <= bit_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) state <= STOP;
        end
`endif
        STOP: begin
          if (tick) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              state       <= IDLE;
              commit      <= 1'b1;
              commit_ferr <= ferr_acc | ~rx_s;
            end else begin
              stop_cnt <= 1'b1;
              ferr_acc <= ferr_acc | ~rx_s;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holding register: a commit always wins over consumption; overwrite of an unread word pulses overrun
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= commit && data_valid && !data_ready;
      if (commit) begin
        data_out   <= shift;
        frame_err  <= commit_ferr;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic [1:0] mode_q;
  logic       perr_q;
  logic       perr_hold;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= PAR_NONE;
      perr_q    <= 1'b0;
      perr_hold <= 1'b0;
    end else begin
      if (start_edge) begin
        mode_q <= parity_mode;
        perr_q <= 1'b0;
      end else if (tick && (state == PARITY)) begin
        perr_q <= (^shift) ^ rx_s ^ (mode_q == PAR_ODD);
      end
      if (commit) perr_hold <= perr_q;
    end
  end

  assign par_active = (mode_q == PAR_EVEN) || (mode_q == PAR_ODD);
  assign parity_err = perr_hold;
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
  assign par_active         = 1'b0;
  assign parity_err         = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed plus randomized bench for uart_rx_core; frames are driven bit by bit
// and compared against a frame-level reference model (word, flags, commit cycle).
module tb_uart_rx_core;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned DIV      = 10;
  localparam int unsigned HALF     = 5;
  localparam int unsigned NB       = 8;
  localparam int unsigned NSTOP    = 1;
  localparam int unsigned SYNC     = 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic [1:0]    parity_mode = 2'b00;
  logic          data_ready = 1'b1;
  logic [NB-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;
  logic          busy;

  uart_rx_core #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .DATA_BITS   (NB),
    .STOP_BITS   (NSTOP),
    .SYNC_STAGES (SYNC)
  ) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .parity_mode (parity_mode),
    .data_ready  (data_ready),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    logic [NB-1:0] d;
    logic          fe;
    logic          pe;
    int            t;
  } ev_t;

  ev_t got_q[$];
  ev_t exp_q[$];
  bit  mon_en = 1'b1;
  int  ov_cnt = 0;
  int  checks = 0;
  int  errors = 0;

  always @(negedge sys_clk) begin
    ev_t g;
    if (mon_en && rst_n && data_valid && data_ready) begin
      g.d = data_out;
      g.fe = frame_err;
      g.pe = parity_err;
      g.t = cyc;
      got_q.push_back(g);
    end
    if (overrun) ov_cnt++;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Even mode: data plus parity bit must hold an even number of ones; odd mode: odd
  function automatic logic exp_perr(input logic [NB-1:0] d, input logic p, input logic [1:0] mode);
    if (!PAR_BUILT || !(mode == 2'b01 || mode == 2'b10)) return 1'b0;
    return ((($countones(d) + int'(p)) % 2) == 1) != (mode == 2'b10);
  endfunction

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (DIV) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_frame(input logic [NB-1:0] d, input logic [1:0] mode, input logic p,
                            input logic stopv, input int gap, input bit expect_it);
    ev_t e;
    bit  par_on;
    int  t0;
    par_on = PAR_BUILT && (mode == 2'b01 || mode == 2'b10);
    parity_mode = mode;
    @(posedge sys_clk);
    #1;
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < int'(NB); i++) drive_bit(d[i]);
    if (par_on) drive_bit(p);
    for (int i = 0; i < int'(NSTOP); i++) drive_bit(stopv);
    rx = 1'b1;
    repeat (gap) @(posedge sys_clk);
    #1;
    if (expect_it) begin
      e.d = d;
      e.fe = !stopv;
      e.pe = exp_perr(d, p, mode);
      e.t = t0 + SYNC + HALF + (NB + (par_on ? 1 : 0) + NSTOP) * DIV + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic get_check(input string tag);
    ev_t g;
    ev_t e;
    int  n;
    n = 0;
    while (got_q.size() == 0 && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    e = exp_q.pop_front();
    chk({tag, "_commit"}, 32'(got_q.size() != 0), 1);
    if (got_q.size() == 0) return;
    g = got_q.pop_front();
    chk({tag, "_data"}, 32'(g.d), 32'(e.d));
    chk({tag, "_frame_err"}, 32'(g.fe), 32'(e.fe));
    chk({tag, "_parity_err"}, 32'(g.pe), 32'(e.pe));
    chk({tag, "_cycle"}, g.t, e.t);
  endtask

  initial begin
    logic [NB-1:0] rd;
    logic [1:0]    rm;
    logic          rp;
    logic          rs;
    ev_t           e;
    int            t0;
    int            ov0;

    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_data_valid", 32'(data_valid), 0);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_parity_err", 32'(parity_err), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1;
    chk("idle_busy", 32'(busy), 0);

    // 8N1 0xA5 with immediate consumption
    send_frame(8'hA5, 2'b00, 1'b0, 1'b1, 20, 1'b1);
    get_check("t1_a5");
    chk("t1_single_valid", got_q.size(), 0);

    // Short low glitch is rejected at the start-bit mid sample
    @(posedge sys_clk);
    #1;
    rx = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    rx = 1'b1;
    chk("t2_busy_start", 32'(busy), 1);
    repeat (20) @(posedge sys_clk);
    #1;
    chk("t2_busy_idle", 32'(busy), 0);
    repeat (120) @(posedge sys_clk);
    #1;
    chk("t2_no_data", got_q.size(), 0);

    // Bad stop bit, then a clean frame clears the flag
    send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 20, 1'b1);
    get_check("t3_3c");
    send_frame(8'h01, 2'b00, 1'b0, 1'b1, 20, 1'b1);
    get_check("t3_01");

    // Two back-to-back frames with the consumer stalled
    mon_en = 1'b0;
    data_ready = 1'b0;
    ov0 = ov_cnt;
    send_frame(8'h11, 2'b00, 1'b0, 1'b1, 0, 1'b0);
    send_frame(8'h22, 2'b00, 1'b0, 1'b1, 20, 1'b0);
    chk("t4_overrun_pulses", ov_cnt - ov0, 1);
    chk("t4_valid_held", 32'(data_valid), 1);
    chk("t4_data", 32'(data_out), 32'h22);
    data_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("t4_consumed", 32'(data_valid), 0);
    mon_en = 1'b1;

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 2'b01, 1'b1, 1'b1, 20, 1'b1);
    get_check("t5_even_p1");
    send_frame(8'h07, 2'b01, 1'b0, 1'b1, 20, 1'b1);
    get_check("t5_even_p0");
    chk("t5_even_p0_flag", 32'(parity_err), 1);
    send_frame(8'h07, 2'b10, 1'b1, 1'b1, 20, 1'b1);
    get_check("t5_odd_p1");
    chk("t5_odd_p1_flag", 32'(parity_err), 1);
    send_frame(8'h07, 2'b10, 1'b0, 1'b1, 20, 1'b1);
    get_check("t5_odd_p0");
`else
    send_frame(8'h07, 2'b01, 1'b1, 1'b1, 20, 1'b1);
    get_check("t5_no_parity");
    chk("t5_parity_err_tied", 32'(parity_err), 0);
`endif

    for (int k = 0; k < 8; k++) begin
      rd = NB'($urandom);
      rm = 2'($urandom_range(0, 3));
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rd, rm, rp, rs, 20, 1'b1);
      get_check("rand");
    end

    // Break: line held low for many bit times yields exactly one errored zero word
    parity_mode = 2'b00;
    @(posedge sys_clk);
    #1;
    t0 = cyc;
    rx = 1'b0;
    repeat (25 * DIV) @(posedge sys_clk);
    #1;
    e.d = '0;
    e.fe = 1'b1;
    e.pe = 1'b0;
    e.t = t0 + SYNC + HALF + (NB + NSTOP) * DIV + 1;
    exp_q.push_back(e);
    get_check("brk");
    chk("brk_single", got_q.size(), 0);
    chk("brk_busy", 32'(busy), 0);
    rx = 1'b1;
    repeat (30) @(posedge sys_clk);
    #1;

    // Reset in the middle of bit 4 of 0xFF discards the frame
    @(posedge sys_clk);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (DIV / 2) @(posedge sys_clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_data_out", 32'(data_out), 0);
    rst_n = 1'b1;
    repeat (8 * DIV) @(posedge sys_clk);
    #1;
    chk("t6_no_valid", 32'(data_valid), 0);
    chk("t6_no_data", got_q.size(), 0);
    send_frame(8'h5A, 2'b00, 1'b0, 1'b1, 20, 1'b1);
    get_check("t6_5a");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
